// File: rtl/mojo_pkg.sv
// Shared Mojo board definitions: UART framing constants, clock/baud defaults
// and the serial transmitter state encoding.
package mojo_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned MOJO_CLK_HZ    = 50_000_000;
  localparam int unsigned AVR_BAUD       = 500_000;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/avr_serial_tx_if.sv
// Byte handshake between fabric logic and the AVR transmitter:
// data/new_data offered by the producer, ready returned by the transmitter.
interface avr_serial_tx_if;
  import mojo_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      new_data;
  logic                      ready;

  modport master (output data, output new_data, input ready);
  modport slave  (input data, input new_data, output ready);

endinterface

// File: rtl/avr_serial_tx_fifo.sv
// Register-based single-clock FIFO; pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avr_serial_tx.sv
// FPGA-to-AVR 8N1 UART transmitter with byte FIFO and avr_rx_busy flow control,
// checked only at frame boundaries.
module avr_serial_tx
  import mojo_pkg::*;
#(
  parameter  int unsigned CLK_PER_BIT = MOJO_CLK_HZ / AVR_BAUD,
  parameter  int unsigned FIFO_DEPTH  = 16,
  localparam int unsigned CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  avr_serial_tx_if.slave              bus,
  input  logic                        block,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam logic [CTR_SIZE-1:0] CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);

  tx_state_t                 state, state_n;
  logic [CTR_SIZE-1:0]       ctr, ctr_n;
  logic [2:0]                bit_idx, bit_idx_n, next_idx;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic                      tx_n;
  logic                      block_m, block_s;
  logic [UART_DATA_BITS-1:0] head;
  logic                      full, empty, pop;
  logic                      launch, bit_done;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.new_data),
    .wdata (bus.data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign bus.ready = !full;
  assign busy      = (state != IDLE) || (fifo_count != '0);

  // Synchroniser resets to "blocked" so nothing leaves before the AVR line is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_m <= 1'b1;
      block_s <= 1'b1;
    end else begin
      block_m <= block;
      block_s <= block_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ctr     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      ctr     <= ctr_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  assign launch   = !empty && !block_s;
  assign bit_done = (ctr == CTR_LAST);
  assign next_idx = bit_idx + 3'd1;

  // tx_n is the line level for the state being entered, so tx is a pure register.
  always_comb begin
    state_n   = state;
    ctr_n     = ctr;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (launch) begin
          pop     = 1'b1;
          shift_n = head;
          ctr_n   = '0;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          ctr_n     = '0;
          bit_idx_n = '0;
          state_n   = DATA;
          tx_n      = shift[0];
        end else begin
          ctr_n = ctr + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          ctr_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = next_idx;
            tx_n      = shift[next_idx];
          end
        end else begin
          ctr_n = ctr + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          ctr_n = '0;
          // Same decision as IDLE so back-to-back frames carry no idle bit.
          if (launch) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          ctr_n = ctr + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_avr_serial_tx.sv
// Bench for avr_serial_tx: stimulus queues expected bytes with their accept cycle,
// a line monitor decodes frames and checks timing against a block-history model.
module tb_avr_serial_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [7:0] b;
    int         acc;
  } sb_entry_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          blk = 1'b0;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;

  int        total = 0;
  int        bad = 0;
  int        cyc = 0;
  int        prev_end = 0;
  bit        in_frame = 1'b0;
  bit        hist [0:65535];
  sb_entry_t sb[$];

  avr_serial_tx_if bus ();

  avr_serial_tx #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .block      (blk),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Effective block seen by a launch decision at edge t is hist[t-3].
  always @(negedge clk) if (cyc < 65536) hist[cyc] <= blk | ~rst_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b, input bit acc_exp);
    bus.data     = b;
    bus.new_data = 1'b1;
    @(posedge clk);
    #1;
    bus.new_data = 1'b0;
    if (acc_exp) sb.push_back('{b: b, acc: cyc});
  endtask

  task automatic wait_room();
    int n = 0;
    while (sb.size() > 2 && n < 3000) begin
      blk = 1'b0;
      idle(1);
      n++;
    end
    if (n >= 3000) check("room_timeout", n, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy || in_frame) && n < 3000) begin
      idle(1);
      n++;
    end
    check("drain_in_time", n < 3000, 1);
  endtask

  initial begin : monitor
    sb_entry_t  e;
    int         s;
    int         t;
    logic [9:0] bits;
    bit         shape_ok;
    bit         aborted;
    bit         have;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        prev_end = 0;
      end else if (tx === 1'b0) begin
        in_frame = 1'b1;
        s    = cyc;
        have = (sb.size() != 0);
        check("frame_queued", have, 1);
        if (have) e = sb.pop_front();
        else e = '{b: 8'h00, acc: s - 1};
        t = e.acc + 1;
        if (prev_end > t) t = prev_end;
        while (t <= s + 1 && hist[t-3]) t++;
        if (have) check("start_cycle", s, t);
        bits     = '0;
        shape_ok = 1'b1;
        aborted  = 1'b0;
        for (int i = 0; i < 10 * CPB; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (i % CPB == 0) bits[i/CPB] = tx;
          else if (tx !== bits[i/CPB]) shape_ok = 1'b0;
        end
        if (aborted) begin
          sb.delete();
          prev_end = 0;
        end else begin
          check("stop_bit", bits[9], 1);
          check("data_byte", bits[8:1], e.b);
          check("bit_shape", shape_ok, 1);
          prev_end = s + 10 * CPB;
        end
        in_frame = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bus.data     = '0;
    bus.new_data = 1'b0;

    // Reset state
    idle(3);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.ready, 1);
    check("rst_count", fifo_count, 0);
    rst_n = 1'b1;
    idle(4);

    // Single byte 0xA5: busy until edge accept+41
    push(8'hA5, 1'b1);
    check("single_count", fifo_count, 1);
    idle(40);
    check("single_busy_last", busy, 1);
    idle(1);
    check("single_busy_end", busy, 0);
    check("single_tx_idle", tx, 1);
    idle(3);

    // Back-to-back 0x00 then 0xFF; second push coincides with the first pop
    push(8'h00, 1'b1);
    check("b2b_count1", fifo_count, 1);
    push(8'hFF, 1'b1);
    check("b2b_count2", fifo_count, 1);
    idle(40);
    check("b2b_count3", fifo_count, 0);
    check("b2b_busy", busy, 1);
    drain();

    // Overflow while blocked
    blk = 1'b1;
    idle(3);
    for (int i = 0; i < 6; i++) begin
      push(8'h10 + 8'(i), i < DEPTH);
      check("ovf_count", fifo_count, (i + 1 < DEPTH) ? i + 1 : DEPTH);
      check("ovf_ready", bus.ready, (i + 1 < DEPTH) ? 1 : 0);
    end
    idle(20);
    check("ovf_held_tx", tx, 1);
    blk = 1'b0;
    drain();

    // Flow control: block asserted during frame 0 data bits
    push(8'h96, 1'b1);
    push(8'h3A, 1'b1);
    idle(2 * CPB);
    blk = 1'b1;
    idle(60);
    check("fc_tx_held", tx, 1);
    check("fc_count", fifo_count, 1);
    check("fc_busy", busy, 1);
    blk = 1'b0;
    idle(2);
    check("fc_tx_before", tx, 1);
    idle(1);
    check("fc_tx_start", tx, 0);
    drain();

    // Reset in the middle of data bit 3 of 0xA5 (bit 3 = 0)
    push(8'hA5, 1'b1);
    push(8'hC3, 1'b1);
    idle(17);
    check("pre_rst_tx", tx, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_ready", bus.ready, 1);
    idle(2);
    rst_n = 1'b1;
    idle(4);
    push(8'h3C, 1'b1);
    drain();

    // Pointer wrap: 0x00..0x09 interleaved with draining
    for (int i = 0; i < 10; i++) begin
      wait_room();
      push(8'(i), 1'b1);
      idle($urandom_range(0, 20));
    end
    drain();

    // Random bytes, random gaps, random block toggles
    for (int i = 0; i < 30; i++) begin
      wait_room();
      if ($urandom_range(0, 7) == 0) blk = ~blk;
      push(8'($urandom()), 1'b1);
      idle($urandom_range(0, 25));
    end
    blk = 1'b0;
    drain();

    check("final_queue", sb.size(), 0);
    check("final_busy", busy, 0);
    check("final_count", fifo_count, 0);
    check("final_tx", tx, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
